// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port register file with NUM_RD combinational read ports,
//            two clocked write ports with same-cycle write-to-read bypass,
//            hard-wired zero register and a per-register pending-write
//            scoreboard with an occupancy counter.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pending;
    logic [DEPTH-1:0]  w_pending_nxt;
    logic [ADDR_W:0]   r_busy_cnt;
    logic [ADDR_W:0]   w_busy_cnt_nxt;

    // Write qualifiers: writes and reservations to register 0 are discarded.
    logic w_wa_ok, w_wb_ok, w_rsv_ok;
    assign w_wa_ok  = wa_en  && (wa_addr  != '0);
    assign w_wb_ok  = wb_en  && (wb_addr  != '0);
    assign w_rsv_ok = rsv_en && (rsv_addr != '0);

    // Data array: port B is applied last so it wins a same-address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_wa_ok) r_regs[wa_addr] <= wa_data;
            if (w_wb_ok) r_regs[wb_addr] <= wb_data;
        end
    end

    // Next pending bits: a new reservation outranks a same-cycle write.
    always_comb begin
        w_pending_nxt = r_pending;
        w_pending_nxt[0] = 1'b0;
        for (int r = 1; r < DEPTH; r++) begin
            if (w_rsv_ok && (rsv_addr == ADDR_W'(r))) begin
                w_pending_nxt[r] = 1'b1;
            end else if ((w_wa_ok && (wa_addr == ADDR_W'(r))) ||
                         (w_wb_ok && (wb_addr == ADDR_W'(r)))) begin
                w_pending_nxt[r] = 1'b0;
            end
        end
    end

    // Incremental occupancy update: at most one set and two clears per cycle.
    logic w_inc, w_dec_a, w_dec_b;
    assign w_inc   = w_rsv_ok && !r_pending[rsv_addr];
    assign w_dec_a = w_wa_ok && r_pending[wa_addr] &&
                     !(w_rsv_ok && (rsv_addr == wa_addr));
    // A clear by B on the address A already cleared must not count twice.
    assign w_dec_b = w_wb_ok && r_pending[wb_addr] &&
                     !(w_rsv_ok && (rsv_addr == wb_addr)) &&
                     !(w_wa_ok && (wa_addr == wb_addr));

    // Combinational next count derived from the individual set/clear events.
    always_comb begin
        w_busy_cnt_nxt = r_busy_cnt + (ADDR_W+1)'(w_inc)
                                    - (ADDR_W+1)'(w_dec_a)
                                    - (ADDR_W+1)'(w_dec_b);
    end

    // Scoreboard state: pending bits and their population count move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end

    assign busy_cnt = r_busy_cnt;

    // Read ports: zero register, then B bypass, then A bypass, then array.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_a;
        logic              w_hit_a, w_hit_b, w_zero;
        assign w_a     = rd_addr[i*ADDR_W +: ADDR_W];
        assign w_zero  = (w_a == '0);
        assign w_hit_a = wa_en && (wa_addr == w_a);
        assign w_hit_b = wb_en && (wb_addr == w_a);

        assign rd_data[i*DATA_W +: DATA_W] = w_zero  ? '0      :
                                             w_hit_b ? wb_data :
                                             w_hit_a ? wa_data :
                                                       r_regs[w_a];
        // Bypassed data is already valid, so a same-cycle write lifts the stall.
        assign rd_busy[i] = !w_zero && r_pending[w_a] && !w_hit_a && !w_hit_b;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Scoreboard bench for regfile_mp. Stimulus pushes expected
//            responses into a queue; a monitor pops and compares them at each
//            sample point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    localparam int K_D0 = 0, K_D1 = 1, K_B0 = 2, K_B1 = 3, K_CNT = 4;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wa_en, wb_en, rsv_en;
    logic [ADDR_W-1:0]        wa_addr, wb_addr, rsv_addr;
    logic [DATA_W-1:0]        wa_data, wb_data;
    logic [ADDR_W:0]          busy_cnt;

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_cnt(busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: at every sample point drain the queue against the DUT outputs.
    initial begin
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = q.pop_front();
                case (e.kind)
                    K_D0:    act = rd_data[0*DATA_W +: DATA_W];
                    K_D1:    act = rd_data[1*DATA_W +: DATA_W];
                    K_B0:    act = {31'd0, rd_busy[0]};
                    K_B1:    act = {31'd0, rd_busy[1]};
                    default: act = {26'd0, busy_cnt};
                endcase
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_v(input string nm, input int kind, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.exp  = v;
        q.push_back(e);
    endtask

    // Expect both ports' data, busy flags and the counter in one go.
    task automatic expect_all(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                              input logic b0, input logic b1, input int cnt);
        expect_v({nm, ".d0"},  K_D0,  d0);
        expect_v({nm, ".d1"},  K_D1,  d1);
        expect_v({nm, ".b0"},  K_B0,  {31'd0, b0});
        expect_v({nm, ".b1"},  K_B1,  {31'd0, b1});
        expect_v({nm, ".cnt"}, K_CNT, cnt);
    endtask

    task automatic fire();
        ->sample_ev;
        #1;
    endtask

    // Start a new cycle on the falling edge with all enables low.
    task automatic cyc(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        @(negedge clk);
        wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0;
        rd_addr = {a1, a0};
    endtask

    task automatic wr_a(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wa_en = 1'b1; wa_addr = a; wa_data = d;
    endtask

    task automatic wr_b(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
    endtask

    task automatic rsv(input logic [ADDR_W-1:0] a);
        rsv_en = 1'b1; rsv_addr = a;
    endtask

    initial begin
        rst_n = 1'b0;
        wa_en = 1'b0; wb_en = 1'b0; rsv_en = 1'b0;
        wa_addr = '0; wb_addr = '0; rsv_addr = '0;
        wa_data = '0; wb_data = '0; rd_addr = '0;

        // Reset: every register reads zero and nothing is pending.
        for (int a = 1; a < 32; a++) begin
            rd_addr = {5'(32 - a), 5'(a)};
            #1;
            expect_all("reset", 32'h0, 32'h0, 1'b0, 1'b0, 0);
            fire();
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Write r5 on A: bypass same cycle, array next cycle.
        cyc(5'd5, 5'd5); wr_a(5'd5, 32'hDEADBEEF); #1;
        expect_all("wr5_byp", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 0); fire();
        cyc(5'd5, 5'd5); #1;
        expect_all("wr5_arr", 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 0); fire();

        // Writes to r0 are ignored.
        cyc(5'd0, 5'd0); wr_a(5'd0, 32'h1234); #1;
        expect_all("r0_byp", 32'h0, 32'h0, 1'b0, 1'b0, 0); fire();
        cyc(5'd0, 5'd5); #1;
        expect_all("r0_arr", 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 0); fire();

        // A and B to r7 in the same cycle: B wins.
        cyc(5'd7, 5'd7); wr_a(5'd7, 32'h11111111); wr_b(5'd7, 32'h22222222); #1;
        expect_all("prio_byp", 32'h22222222, 32'h22222222, 1'b0, 1'b0, 0); fire();
        cyc(5'd7, 5'd5); #1;
        expect_all("prio_arr", 32'h22222222, 32'hDEADBEEF, 1'b0, 1'b0, 0); fire();

        // Reserve r3: busy appears only after the edge.
        cyc(5'd3, 5'd7); rsv(5'd3); #1;
        expect_all("rsv3_now", 32'h0, 32'h22222222, 1'b0, 1'b0, 0); fire();
        cyc(5'd3, 5'd7); #1;
        expect_all("rsv3_next", 32'h0, 32'h22222222, 1'b1, 1'b0, 1); fire();
        cyc(5'd3, 5'd3); wr_b(5'd3, 32'hA5); #1;
        expect_all("wb3_byp", 32'hA5, 32'hA5, 1'b0, 1'b0, 1); fire();
        cyc(5'd3, 5'd3); #1;
        expect_all("wb3_after", 32'hA5, 32'hA5, 1'b0, 1'b0, 0); fire();

        // Reserve r4 then r6.
        cyc(5'd4, 5'd6); rsv(5'd4); #1;
        expect_all("rsv4", 32'h0, 32'h0, 1'b0, 1'b0, 0); fire();
        cyc(5'd4, 5'd6); rsv(5'd6); #1;
        expect_all("rsv6", 32'h0, 32'h0, 1'b1, 1'b0, 1); fire();

        // Re-reserve r4 while A writes it: stays pending, count unchanged.
        cyc(5'd4, 5'd6); rsv(5'd4); wr_a(5'd4, 32'hCAFE0004); #1;
        expect_all("rsvwr4_now", 32'hCAFE0004, 32'h0, 1'b0, 1'b1, 2); fire();
        cyc(5'd4, 5'd6); #1;
        expect_all("rsvwr4_next", 32'hCAFE0004, 32'h0, 1'b1, 1'b1, 2); fire();

        // Reserve r9 while A clears r4 and B clears r6: net -1.
        cyc(5'd4, 5'd6); rsv(5'd9); wr_a(5'd4, 32'h44); wr_b(5'd6, 32'h66); #1;
        expect_all("net_now", 32'h44, 32'h66, 1'b0, 1'b0, 2); fire();
        cyc(5'd9, 5'd4); #1;
        expect_all("net_next", 32'h0, 32'h44, 1'b1, 1'b0, 1); fire();

        // Build three pending registers: r9, r10, r11.
        cyc(5'd10, 5'd11); rsv(5'd10); #1;
        expect_all("rsv10", 32'h0, 32'h0, 1'b0, 1'b0, 1); fire();
        cyc(5'd10, 5'd11); rsv(5'd11); #1;
        expect_all("rsv11", 32'h0, 32'h0, 1'b1, 1'b0, 2); fire();
        cyc(5'd10, 5'd11); #1;
        expect_all("three_pend", 32'h0, 32'h0, 1'b1, 1'b1, 3); fire();

        // Asynchronous reset between edges clears everything at once.
        cyc(5'd9, 5'd4); #1;
        expect_all("pre_rst", 32'h0, 32'h44, 1'b1, 1'b0, 3); fire();
        #1;
        rst_n = 1'b0;
        #1;
        expect_all("async_rst", 32'h0, 32'h0, 1'b0, 1'b0, 0); fire();
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr = {5'd5, 5'd10};
        #1;
        expect_all("post_rst", 32'h0, 32'h0, 1'b0, 1'b0, 0); fire();

        #5;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
